// File: rtl/aes_block_packer.sv
// ============================================================================
// Module  : aes_block_packer
// Brief   : Packs a byte stream into 128-bit blocks with PKCS#7 padding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_block_packer #(
  parameter int PAD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [127:0]     blk_data,
  output logic             blk_valid,
  output logic             blk_last,
  input  logic             blk_ready,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [127:0] c_pad_blk = {16{8'h10}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_idx;
  logic [3:0]         w_idx_nxt;
  logic               r_pend_pad;
  logic               w_pend_nxt;
  logic [127:0]       r_data;
  logic [127:0]       w_data_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         w_pad_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_idx      <= 4'd0;
      r_pend_pad <= 1'b0;
      r_data     <= 128'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_pend_pad <= w_pend_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend_pad;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    // PKCS#7 pad value equals the count of bytes still missing after this one
    w_pad_byte  = (PAD_EN != 0) ? {4'h0, 4'hF - r_idx} : 8'h00;

    case (r_state)
      ST_FILL: begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) begin
            if (4'(i) == r_idx) begin
              w_data_nxt[127-8*i -: 8] = in_data;
            end else if (in_last && (4'(i) > r_idx)) begin
              w_data_nxt[127-8*i -: 8] = w_pad_byte;
            end
          end
          w_idx_nxt = r_idx + 4'd1;
          if (in_last || (r_idx == 4'hF)) begin
            w_state_nxt = ST_HOLD;
            w_valid_nxt = 1'b1;
            // A full final block needs a whole extra pad block behind it
            if (in_last && (r_idx == 4'hF) && (PAD_EN != 0)) begin
              w_last_nxt = 1'b0;
              w_pend_nxt = 1'b1;
            end else begin
              w_last_nxt = in_last;
            end
          end
        end
      end
      ST_HOLD: begin
        if (blk_ready) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_pend_pad) begin
            w_data_nxt = c_pad_blk;
            w_last_nxt = 1'b1;
            w_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_FILL;
            w_idx_nxt   = 4'd0;
            w_data_nxt  = 128'd0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  assign in_ready  = rst_n & (r_state == ST_FILL);
  assign blk_data  = r_data;
  assign blk_valid = r_valid;
  assign blk_last  = r_last;
  assign blk_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_aes_block_packer.sv
// ============================================================================
// Module  : tb_aes_block_packer
// Brief   : Randomized bench for aes_block_packer, PAD_EN=1 and PAD_EN=0 copies.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_block_packer;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [2];
  logic [7:0]   in_data   [2];
  logic         in_valid  [2];
  logic         in_last   [2];
  logic         in_ready  [2];
  logic [127:0] blk_data  [2];
  logic         blk_valid [2];
  logic         blk_last  [2];
  logic         blk_ready [2];
  logic [15:0]  cnt1;
  logic [3:0]   cnt0;

  int           n_chk = 0;
  int           n_err = 0;
  int           exp_cnt [2];
  bit           bp_hold = 1'b0;
  logic [7:0]   msg_q [$];
  logic [128:0] got_q [$];
  logic [128:0] first_got;

  aes_block_packer #(.PAD_EN(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .blk_data(blk_data[0]),
    .blk_valid(blk_valid[0]), .blk_last(blk_last[0]), .blk_ready(blk_ready[0]),
    .blk_cnt(cnt0)
  );

  aes_block_packer #(.PAD_EN(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .blk_data(blk_data[1]),
    .blk_valid(blk_valid[1]), .blk_last(blk_last[1]), .blk_ready(blk_ready[1]),
    .blk_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, obs, want);
    end
  endtask

  initial begin
    blk_ready[0] = 1'b0;
    blk_ready[1] = 1'b0;
    forever begin
      @(negedge clk);
      blk_ready[0] = !bp_hold && ($urandom_range(3) != 0);
      blk_ready[1] = !bp_hold && ($urandom_range(3) != 0);
    end
  end

  // Collect every handed-off block and watch that a stalled block stays put
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [127:0] prev;
    bit           held;
    initial begin
      held = 1'b0;
      forever begin
        @(negedge clk);
        #2;
        if (rst_n[g] && blk_valid[g]) begin
          if (held) chk("hold_stable", blk_data[g], prev);
          if (blk_ready[g]) begin
            got_q.push_back({blk_last[g], blk_data[g]});
            held = 1'b0;
          end else begin
            held = 1'b1;
            prev = blk_data[g];
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic send(input int s, input bit last_on_end);
    int t;
    int gap;
    bit acc;
    for (int i = 0; i < msg_q.size(); i++) begin
      gap = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
      repeat (gap) begin
        @(negedge clk);
        in_valid[s] = 1'b0;
        in_data[s]  = 8'($urandom);
        in_last[s]  = 1'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      in_valid[s] = 1'b1;
      in_data[s]  = msg_q[i];
      in_last[s]  = last_on_end && (i == msg_q.size() - 1);
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        #1 acc = in_ready[s];
        @(posedge clk);
        if (!acc) begin
          t++;
          if (t > 100) begin
            chk("accept_timeout", 128'(t), 128'd0);
            in_valid[s] = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  // Reference: pad the whole message, then cut it into 16-byte blocks
  task automatic run_msg(input int s, input bit bp);
    logic [128:0] want [$];
    logic [7:0]   b [$];
    logic [127:0] d;
    logic [127:0] held;
    int           p;
    int           t;
    int           nb;
    b = msg_q;
    if (s == 1) begin
      p = 16 - (b.size() % 16);
      repeat (p) b.push_back(8'(p));
    end else begin
      while (b.size() % 16 != 0) b.push_back(8'h00);
    end
    nb = b.size() / 16;
    for (int k = 0; k < nb; k++) begin
      d = 128'd0;
      for (int j = 0; j < 16; j++) d = {d[119:0], b[16*k+j]};
      want.push_back({(k == nb - 1), d});
    end
    got_q.delete();
    if (bp) begin
      bp_hold = 1'b1;
      fork
        send(s, 1'b1);
        begin
          t = 0;
          while (!blk_valid[s] && t < 100) begin
            @(negedge clk);
            #3;
            t++;
          end
          held = blk_data[s];
          repeat (5) begin
            @(negedge clk);
            #3;
            chk("bp_valid", 128'(blk_valid[s]), 128'd1);
            chk("bp_data", blk_data[s], held);
            chk("bp_in_ready", 128'(in_ready[s]), 128'd0);
          end
          bp_hold = 1'b0;
        end
      join
    end else begin
      send(s, 1'b1);
    end
    t = 0;
    while (got_q.size() < want.size() && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("blocks_seen", 128'(got_q.size()), 128'(want.size()));
    for (int k = 0; k < want.size(); k++) begin
      if (k < got_q.size()) begin
        chk("blk_data", got_q[k][127:0], want[k][127:0]);
        chk("blk_last", 128'(got_q[k][128]), 128'(want[k][128]));
      end
    end
    first_got = (got_q.size() > 0) ? got_q[0] : 129'd0;
    exp_cnt[s] += want.size();
    if (s == 1) chk("blk_cnt", 128'(cnt1), 128'(exp_cnt[1] % 65536));
    else        chk("blk_cnt", 128'(cnt0), 128'(exp_cnt[0] % 16));
  endtask

  task automatic set_seq(input int n, input int base);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(base + i));
  endtask

  task automatic set_hello();
    msg_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
  endtask

  task automatic set_rand();
    int n;
    n = int'($urandom_range(40, 1));
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s]    = 1'b0;
      in_data[s]  = 8'h00;
      in_valid[s] = 1'b0;
      in_last[s]  = 1'b0;
      exp_cnt[s]  = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 128'(blk_valid[s]), 128'd0);
      chk("rst_last", 128'(blk_last[s]), 128'd0);
      chk("rst_data", blk_data[s], 128'd0);
      chk("rst_in_ready_low", 128'(in_ready[s]), 128'd0);
    end
    chk("rst_cnt1", 128'(cnt1), 128'd0);
    chk("rst_cnt0", 128'(cnt0), 128'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    chk("rst_in_ready0", 128'(in_ready[0]), 128'd1);
    chk("rst_in_ready1", 128'(in_ready[1]), 128'd1);

    set_hello();
    run_msg(1, 1'b0);
    chk("hello_const", first_got[127:0], 128'h48656c6c6f210a0a0a0a0a0a0a0a0a0a);
    set_seq(16, 0);
    run_msg(1, 1'b0);
    set_seq(17, 0);
    run_msg(1, 1'b0);
    set_seq(20, 8'h40);
    run_msg(1, 1'b1);

    set_seq(7, 8'h80);
    send(1, 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_valid", 128'(blk_valid[1]), 128'd0);
    chk("midrst_cnt", 128'(cnt1), 128'd0);
    chk("midrst_data", blk_data[1], 128'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready[1]), 128'd1);
    exp_cnt[1] = 0;
    set_hello();
    run_msg(1, 1'b0);
    chk("hello_again", first_got[127:0], 128'h48656c6c6f210a0a0a0a0a0a0a0a0a0a);

    set_hello();
    run_msg(0, 1'b0);
    chk("hello_nopad", first_got[127:0], 128'h48656c6c6f2100000000000000000000);
    set_seq(16, 0);
    run_msg(0, 1'b0);
    set_seq(20, 8'hA0);
    run_msg(0, 1'b1);
    repeat (14) begin
      set_rand();
      run_msg(0, 1'b0);
    end
    repeat (10) begin
      set_rand();
      run_msg(1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
